// File: rtl/fifo_rd_drainer_pkg.sv
// Shared types and default parameters for the FIFO read-side drainer.
// Optional statistics counters are enabled with FIFO_RD_DRAINER_STATS_EN.
package fifo_rd_drainer_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int BUF_DEPTH_DEF  = 2;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } drainer_state_e;

endpackage

// File: rtl/fifo_rd_drainer_buf.sv
// Small register FIFO holding words captured from the upstream FIFO until the
// downstream consumer accepts them; head is always presented combinationally.
module fifo_rd_drainer_buf #(
  parameter int W     = 16,
  parameter int DEPTH = 2,
  parameter int OW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [OW-1:0] occ,
  output logic [W-1:0]  head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      occ <= occ + OW'(1);
      else if (pop && !push) occ <= occ - OW'(1);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_drainer.sv
// Read-side master for a FIFO with 1-cycle read latency; forwards words on a
// valid/ready stream. Define FIFO_RD_DRAINER_STATS_EN for stall/empty counters.
//
//   state | meaning
//   IDLE  | not reading; buffered words may still drain
//   RUN   | issuing reads whenever FIFO non-empty and buffer credit remains
//   STOP  | en dropped; waiting for the outstanding read to land
module fifo_rd_drainer
  import fifo_rd_drainer_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_W-1:0]      rd_count,
`ifdef FIFO_RD_DRAINER_STATS_EN
  output logic                  err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      empty_cnt
`else
  output logic                  err
`endif
);

  localparam int OW = $clog2(BUF_DEPTH + 1);

  drainer_state_e state;
  logic           inflight_q;
  logic           pop;
  logic           push;
  logic [OW-1:0]  occ;
  logic [OW:0]    credit_used;

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  assign push    = inflight_q && !fifo_underflow;

  // Slots committed after this edge: buffered + landing read - word leaving.
  assign credit_used = {1'b0, occ} + {{OW{1'b0}}, inflight_q} - {{OW{1'b0}}, pop};
  assign fifo_rd_en  = (state == RUN) && !fifo_empty && (credit_used < (OW+1)'(BUF_DEPTH));

  fifo_rd_drainer_buf #(
    .W     (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH),
    .OW    (OW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_data_out),
    .pop       (pop),
    .occ       (occ),
    .head      (m_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      inflight_q <= 1'b0;
      rd_count   <= '0;
      err        <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (pop) rd_count <= rd_count + CNT_W'(1);
      if (inflight_q && fifo_underflow) err <= 1'b1;
      case (state)
        IDLE: if (en) begin
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: if (!en) state <= STOP;
        STOP: if (!inflight_q) begin
          if (en) begin
            state <= RUN;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_RD_DRAINER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      empty_cnt <= '0;
    end else begin
      if (state == RUN && !fifo_empty && !fifo_rd_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (state == RUN && fifo_empty && empty_cnt != '1)
        empty_cnt <= empty_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_drainer.sv
// Bench for fifo_rd_drainer: behavioural FIFO environment plus a queue-based
// reference model compared against the DUT every cycle.
module tb_fifo_rd_drainer;
  localparam int W  = 16;
  localparam int D  = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, en, fifo_empty, fifo_underflow, m_ready;
  logic [W-1:0]  fifo_data_out, m_data;
  logic          fifo_rd_en, m_valid, busy, err;
  logic [CW-1:0] rd_count;
`ifdef FIFO_RD_DRAINER_STATS_EN
  logic [CW-1:0] stall_cnt, empty_cnt;
`endif

  always #5 clk = ~clk;

  fifo_rd_drainer #(.FIFO_WIDTH(W), .BUF_DEPTH(D), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .fifo_data_out  (fifo_data_out),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .busy           (busy),
    .rd_count       (rd_count),
`ifdef FIFO_RD_DRAINER_STATS_EN
    .err            (err),
    .stall_cnt      (stall_cnt),
    .empty_cnt      (empty_cnt)
`else
    .err            (err)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] env_q[$];
  bit           uf_inject;

  // reference model: 0 = idle, 1 = run, 2 = stop
  int           m_st;
  bit           m_inf;
  logic [W-1:0] m_buf[$];
  int           m_cnt;
  bit           m_err;
  int           m_stall, m_empty;

  logic [W-1:0] got[$];
  int           cyc, first_pop, last_pop, rd_pulses, mv_cycles;
  bit           s_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_inf = 0; m_buf.delete(); m_cnt = 0; m_err = 0; m_stall = 0; m_empty = 0;
  endtask

  task automatic fifo_write(input logic [W-1:0] w);
    env_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic tick();
    bit ev, ep, er, s_rst, s_en, s_empty, s_uf, old_inf;
    logic [W-1:0] s_data;
    @(negedge clk);
    ev = (m_buf.size() > 0);
    ep = ev && m_ready;
    er = (m_st == 1) && !fifo_empty && ((m_buf.size() + int'(m_inf) - int'(ep)) < D);
    chk("rd_en", fifo_rd_en, er);
    chk("m_valid", m_valid, ev);
    if (ev) chk("m_data", m_data, m_buf[0]);
    chk("busy", busy, m_st != 0);
    chk("rd_count", rd_count, m_cnt);
    chk("err", err, m_err);
`ifdef FIFO_RD_DRAINER_STATS_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("empty_cnt", empty_cnt, m_empty);
`endif
    s_rst = rst; s_en = en; s_empty = fifo_empty; s_uf = fifo_underflow;
    s_data = fifo_data_out; s_rd = fifo_rd_en;
    if (m_valid && m_ready) begin
      if (got.size() == 0) first_pop = cyc;
      last_pop = cyc;
      got.push_back(m_data);
    end
    rd_pulses += int'(fifo_rd_en);
    mv_cycles += int'(m_valid);
    @(posedge clk);
    #1;
    cyc++;
    if (s_rst) begin
      model_reset();
    end else begin
      if (ep) begin
        void'(m_buf.pop_front());
        m_cnt = (m_cnt + 1) % (1 << CW);
      end
      if (m_inf) begin
        if (s_uf) m_err = 1;
        else m_buf.push_back(s_data);
      end
      if (m_st == 1 && !s_empty && !er && m_stall < (1 << CW) - 1) m_stall++;
      if (m_st == 1 && s_empty && m_empty < (1 << CW) - 1) m_empty++;
      old_inf = m_inf;
      m_inf   = er;
      case (m_st)
        0: if (s_en) m_st = 1;
        1: if (!s_en) m_st = 2;
        default: if (!old_inf) m_st = s_en ? 1 : 0;
      endcase
    end
    fifo_underflow = s_rd && (uf_inject || env_q.size() == 0);
    if (s_rd && env_q.size() > 0) fifo_data_out = env_q.pop_front();
    fifo_empty = (env_q.size() == 0);
  endtask

  initial begin
    rst = 1; en = 1; m_ready = 1; uf_inject = 0;
    fifo_underflow = 0; fifo_data_out = '0; cyc = 0;
    first_pop = 0; last_pop = 0; rd_pulses = 0; mv_cycles = 0; s_rd = 0;
    for (int i = 1; i <= 8; i++) env_q.push_back(W'(i));
    fifo_empty = 0;
    @(posedge clk); #1;
    model_reset();

    // reset with a full upstream FIFO
    repeat (2) tick();
    chk("rst_rd_pulses", rd_pulses, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_err", err, 0);

    // full-throughput drain of 1..8
    rst = 0; got.delete();
    for (int i = 0; i < 40 && got.size() < 8; i++) tick();
    chk("t2_words", got.size(), 8);
    for (int k = 0; k < 8 && k < got.size(); k++) chk("t2_order", got[k], k + 1);
    chk("t2_span", last_pop - first_pop, 7);
    chk("t2_rd_count", rd_count, 8);
    en = 0;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("t2_idle", busy, 0);

    // backpressure: only BUF_DEPTH reads issued
    m_ready = 0;
    for (int i = 0; i < 8; i++) fifo_write(W'(16'h11 + i));
    en = 1; rd_pulses = 0;
    repeat (12) tick();
    chk("t3_rd_pulses", rd_pulses, 2);
    chk("t3_m_valid", m_valid, 1);
    chk("t3_m_data", m_data, 16'h0011);
    m_ready = 1; got.delete();
    for (int i = 0; i < 40 && got.size() < 8; i++) tick();
    chk("t3_words", got.size(), 8);
    if (got.size() == 8) begin
      chk("t3_first", got[0], 16'h0011);
      chk("t3_last", got[7], 16'h0018);
    end

    // empty FIFO, then one word
    rd_pulses = 0;
    repeat (10) tick();
    chk("t4_no_rd", rd_pulses, 0);
    fifo_write(16'hBEEF); got.delete(); mv_cycles = 0;
    repeat (10) tick();
    chk("t4_words", got.size(), 1);
    if (got.size() == 1) chk("t4_data", got[0], 16'hBEEF);
    chk("t4_valid_cycles", mv_cycles, 1);

    // en drops with a read in flight
    fifo_write(16'h5A5A); got.delete(); s_rd = 0;
    for (int i = 0; i < 10 && !s_rd; i++) tick();
    chk("t5_saw_rd", s_rd, 1);
    en = 0;
    tick();
    chk("t5_stop_busy", busy, 1);
    tick();
    chk("t5_idle_busy", busy, 0);
    tick();
    chk("t5_words", got.size(), 1);
    if (got.size() == 1) chk("t5_data", got[0], 16'h5A5A);

    // forced underflow
    en = 1; uf_inject = 1; fifo_write(16'h7777); got.delete(); s_rd = 0;
    for (int i = 0; i < 10 && !s_rd; i++) tick();
    chk("t6_saw_rd", s_rd, 1);
    uf_inject = 0;
    repeat (5) tick();
    chk("t6_err", err, 1);
    chk("t6_no_word", got.size(), 0);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_err_clr", err, 0);

    // randomized traffic with occasional resets and underflows
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 4) < 2 && env_q.size() < 16) fifo_write(W'($urandom));
      uf_inject = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 0; uf_inject = 0; en = 0; m_ready = 1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
